// File: rtl/jpeg_fifo_pkg.sv
// jpeg_fifo_pkg
//   Shared types and constants for the JPEG bitstream FIFO.
//   fwft_state_t : output-stage state for first-word-fall-through mode
//   FIFO_STD     : standard read mode (data one cycle after rd_en)
//   FIFO_FWFT    : first-word-fall-through read mode
package jpeg_fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_VALID   = 2'd2
    } fwft_state_t;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/jpeg_fifo_sdpram.sv
// jpeg_fifo_sdpram
//   Simple dual-port RAM, 2^ADDR_WIDTH x DATA_WIDTH, one write port and one
//   registered read port (1-cycle latency). The array has no reset.
//   A read of an address written on the same edge returns the old contents.
//   Ports:
//     clk     : clock
//     wr_en   : write strobe
//     wr_addr : write address
//     wr_data : write word
//     rd_addr : read address, sampled every rising edge
//     rd_data : registered read word
module jpeg_fifo_sdpram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jpeg_bitstream_sync_fifo.sv
// jpeg_bitstream_sync_fifo
//   Single-clock FIFO between the JPEG entropy coder and the output path.
//   Standard or FWFT read mode, synchronous flush, sticky error flags.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     flush           : synchronous clear of contents (priority over rd/wr)
//     wr_en, wr_data  : write request / word; wr_full, almost_full flags
//     rd_en           : read request (FWFT: pop of the presented word)
//     rd_data,rd_valid: read word and its valid strobe
//     rd_empty, almost_empty : read-side flags
//     water_level     : words held, including the FWFT output word
//     overflow, underflow, clr_err : sticky error flags and their clear
module jpeg_bitstream_sync_fifo
    import jpeg_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 12,
    parameter int          FWFT             = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 2000,
    parameter int unsigned ALMOST_EMPTY_NUM = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_TH = ALMOST_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_TH = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   count, count_nxt, level_nxt;
    logic                  wr_acc, rd_acc, pop_ram, load_out, rd_valid_nxt;
    logic                  ovf_evt, udf_evt;
    fwft_state_t           state, state_nxt;
    logic [DATA_WIDTH-1:0] ram_q, byp_data, head_word;
    logic                  byp_valid;

    // The RAM is read every cycle at the post-update read pointer, so ram_q
    // always shows the head word one cycle later. When the head slot was
    // written on that same edge the RAM returns stale data, so the written
    // word is captured in byp_data and substituted.
    jpeg_fifo_sdpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_nxt),
        .rd_data (ram_q)
    );

    assign head_word = byp_valid ? byp_data : ram_q;

    always_comb begin
        state_nxt    = state;
        rd_acc       = 1'b0;
        pop_ram      = 1'b0;
        load_out     = 1'b0;
        rd_valid_nxt = 1'b0;
        wr_acc       = !flush && wr_en && !wr_full;
        ovf_evt      = !flush && wr_en && wr_full;
        udf_evt      = !flush && rd_en && rd_empty;

        if (FWFT == FIFO_FWFT) begin
            // The RAM word leaves count when it is captured into rd_data.
            pop_ram = !flush && ((state == ST_LOADING) ||
                                 (state == ST_VALID && rd_en && count != '0));
            case (state)
                ST_EMPTY:   if (count != '0) state_nxt = ST_LOADING;
                ST_LOADING: state_nxt = ST_VALID;
                ST_VALID:   if (rd_en && count == '0) state_nxt = ST_EMPTY;
                default:    state_nxt = ST_EMPTY;
            endcase
            if (flush) begin
                state_nxt = ST_EMPTY;
            end
            rd_valid_nxt = (state_nxt == ST_VALID);
            load_out     = pop_ram;
        end else begin
            rd_acc       = !flush && rd_en && !rd_empty;
            pop_ram      = rd_acc;
            rd_valid_nxt = rd_acc;
            load_out     = rd_acc;
        end

        count_nxt  = count + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, pop_ram};
        wr_ptr_nxt = wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, wr_acc};
        rd_ptr_nxt = rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, pop_ram};
        if (flush) begin
            count_nxt  = '0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end

        level_nxt = count_nxt;
        if (FWFT == FIFO_FWFT) begin
            level_nxt = count_nxt + {{ADDR_WIDTH{1'b0}}, rd_valid_nxt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            rd_empty     <= 1'b1;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            water_level  <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rd_data      <= '0;
            byp_valid    <= 1'b0;
            byp_data     <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            rd_valid     <= rd_valid_nxt;
            rd_empty     <= (FWFT == FIFO_FWFT) ? !rd_valid_nxt : (count_nxt == '0);
            wr_full      <= (count_nxt == DEPTH);
            almost_full  <= (level_nxt >= AF_TH);
            almost_empty <= (level_nxt <= AE_TH);
            water_level  <= level_nxt;
            overflow     <= (overflow && !clr_err) || ovf_evt;
            underflow    <= (underflow && !clr_err) || udf_evt;
            if (load_out) begin
                rd_data <= head_word;
            end
            byp_valid <= wr_acc && (wr_ptr == rd_ptr_nxt);
            byp_data  <= wr_data;
        end
    end

endmodule

// File: tb/tb_jpeg_bitstream_sync_fifo.sv
module tb_jpeg_bitstream_sync_fifo;

    logic        clk;
    logic        rst_n;

    logic        s_flush, s_wr_en, s_rd_en, s_clr_err;
    logic [31:0] s_wr_data, s_rd_data;
    logic        s_wr_full, s_almost_full, s_rd_valid, s_rd_empty, s_almost_empty;
    logic [12:0] s_water_level;
    logic        s_overflow, s_underflow;

    logic        f_flush, f_wr_en, f_rd_en, f_clr_err;
    logic [31:0] f_wr_data, f_rd_data;
    logic        f_wr_full, f_almost_full, f_rd_valid, f_rd_empty, f_almost_empty;
    logic [12:0] f_water_level;
    logic        f_overflow, f_underflow;

    int total = 0;
    int bad   = 0;

    jpeg_bitstream_sync_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .FWFT       (0)
    ) dut_std (
        .clk (clk), .rst_n (rst_n), .flush (s_flush),
        .wr_en (s_wr_en), .wr_data (s_wr_data), .wr_full (s_wr_full),
        .almost_full (s_almost_full), .rd_en (s_rd_en), .rd_data (s_rd_data),
        .rd_valid (s_rd_valid), .rd_empty (s_rd_empty),
        .almost_empty (s_almost_empty), .water_level (s_water_level),
        .overflow (s_overflow), .underflow (s_underflow), .clr_err (s_clr_err)
    );

    jpeg_bitstream_sync_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .FWFT       (1)
    ) dut_fwft (
        .clk (clk), .rst_n (rst_n), .flush (f_flush),
        .wr_en (f_wr_en), .wr_data (f_wr_data), .wr_full (f_wr_full),
        .almost_full (f_almost_full), .rd_en (f_rd_en), .rd_data (f_rd_data),
        .rd_valid (f_rd_valid), .rd_empty (f_rd_empty),
        .almost_empty (f_almost_empty), .water_level (f_water_level),
        .overflow (f_overflow), .underflow (f_underflow), .clr_err (f_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std_reset(input string tag);
        check({tag, "_wr_full"},  s_wr_full, 0);
        check({tag, "_afull"},    s_almost_full, 0);
        check({tag, "_level"},    s_water_level, 0);
        check({tag, "_ovf"},      s_overflow, 0);
        check({tag, "_udf"},      s_underflow, 0);
        check({tag, "_valid"},    s_rd_valid, 0);
        check({tag, "_empty"},    s_rd_empty, 1);
        check({tag, "_aempty"},   s_almost_empty, 1);
        check({tag, "_data"},     s_rd_data, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {s_flush, s_wr_en, s_rd_en, s_clr_err} = '0;
        {f_flush, f_wr_en, f_rd_en, f_clr_err} = '0;
        s_wr_data = '0;
        f_wr_data = '0;
        tick();
        tick();
        check_std_reset("std_rst");
        check("fwft_rst_valid", f_rd_valid, 0);
        check("fwft_rst_empty", f_rd_empty, 1);
        check("fwft_rst_level", f_water_level, 0);
        rst_n = 1'b1;
        tick();

        // Standard mode: fill with 4097 descending words, last one overflows.
        for (int i = 0; i <= 4096; i++) begin
            s_wr_en   = 1'b1;
            s_wr_data = 32'hFFFF_FFFF - i;
            tick();
            if (i == 0)    check("std_empty_after_wr", s_rd_empty, 0);
            if (i == 1998) check("std_afull_1999", s_almost_full, 0);
            if (i == 1999) begin
                check("std_afull_2000", s_almost_full, 1);
                check("std_aempty_2000", s_almost_empty, 1);
            end
            if (i == 2000) check("std_aempty_2001", s_almost_empty, 0);
            if (i == 4095) begin
                check("std_full", s_wr_full, 1);
                check("std_level_4096", s_water_level, 4096);
                check("std_no_ovf_yet", s_overflow, 0);
            end
        end
        s_wr_en = 1'b0;
        check("std_ovf", s_overflow, 1);
        check("std_level_after_ovf", s_water_level, 4096);

        for (int i = 0; i < 4096; i++) begin
            s_rd_en = 1'b1;
            tick();
            check("std_rd_data", s_rd_data, 32'hFFFF_FFFF - i);
            check("std_rd_valid", s_rd_valid, 1);
        end
        s_rd_en = 1'b0;
        tick();
        check("std_valid_drop", s_rd_valid, 0);
        check("std_data_hold", s_rd_data, 32'hFFFF_F000);
        check("std_empty_end", s_rd_empty, 1);
        check("std_level_end", s_water_level, 0);
        check("std_no_udf", s_underflow, 0);

        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        check("std_udf", s_underflow, 1);
        check("std_udf_novalid", s_rd_valid, 0);
        s_clr_err = 1'b1;
        tick();
        s_clr_err = 1'b0;
        check("std_clr_ovf", s_overflow, 0);
        check("std_clr_udf", s_underflow, 0);

        // Refill, then read and write together while full.
        for (int i = 0; i < 4096; i++) begin
            s_wr_en   = 1'b1;
            s_wr_data = i;
            tick();
        end
        check("std_refull", s_wr_full, 1);
        s_wr_data = 32'h0000_DEAD;
        s_rd_en   = 1'b1;
        tick();
        check("std_sim1_level", s_water_level, 4095);
        check("std_sim1_full", s_wr_full, 0);
        check("std_sim1_ovf", s_overflow, 1);
        check("std_sim1_data", s_rd_data, 0);
        tick();
        check("std_sim2_level", s_water_level, 4095);
        check("std_sim2_data", s_rd_data, 1);
        s_wr_en = 1'b0;
        for (int i = 0; i < 3995; i++) tick();
        check("std_level_100", s_water_level, 100);
        s_rd_en = 1'b0;
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        check("std_flush_level", s_water_level, 0);
        check("std_flush_empty", s_rd_empty, 1);
        check("std_flush_valid", s_rd_valid, 0);
        check("std_flush_ovf_kept", s_overflow, 1);
        check("std_flush_data_held", s_rd_data, 3996);
        check("std_flush_aempty", s_almost_empty, 1);
        s_clr_err = 1'b1;
        tick();
        s_clr_err = 1'b0;
        check("std_flush_clr", s_overflow, 0);

        s_wr_en   = 1'b1;
        s_wr_data = 32'h0000_1234;
        tick();
        s_wr_en = 1'b0;
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        check("std_post_flush_data", s_rd_data, 32'h0000_1234);
        check("std_post_flush_valid", s_rd_valid, 1);

        // Asynchronous reset in the middle of a write burst.
        s_wr_en   = 1'b1;
        s_wr_data = 32'h0000_0055;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_std_reset("std_midrst");
        s_wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // FWFT: single word falls through two cycles after the write.
        f_wr_en   = 1'b1;
        f_wr_data = 32'hA5A5_A5A5;
        tick();
        f_wr_en = 1'b0;
        check("fwft1_valid_n1", f_rd_valid, 0);
        check("fwft1_level_n1", f_water_level, 1);
        tick();
        check("fwft1_valid_n2", f_rd_valid, 0);
        tick();
        check("fwft1_valid", f_rd_valid, 1);
        check("fwft1_data", f_rd_data, 32'hA5A5_A5A5);
        check("fwft1_empty", f_rd_empty, 0);
        check("fwft1_level", f_water_level, 1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fwft1_pop_empty", f_rd_empty, 1);
        check("fwft1_pop_valid", f_rd_valid, 0);
        check("fwft1_pop_level", f_water_level, 0);
        check("fwft1_no_udf", f_underflow, 0);

        // FWFT: eight words drained back to back, then a ninth read.
        for (int i = 0; i < 8; i++) begin
            f_wr_en   = 1'b1;
            f_wr_data = 32'h100 + i;
            tick();
        end
        f_wr_en = 1'b0;
        tick();
        tick();
        check("fwft8_level", f_water_level, 8);
        for (int i = 0; i < 8; i++) begin
            check("fwft8_valid", f_rd_valid, 1);
            check("fwft8_data", f_rd_data, 32'h100 + i);
            f_rd_en = 1'b1;
            tick();
        end
        f_rd_en = 1'b0;
        check("fwft8_end_valid", f_rd_valid, 0);
        check("fwft8_end_empty", f_rd_empty, 1);
        check("fwft8_end_level", f_water_level, 0);
        check("fwft8_no_udf", f_underflow, 0);
        f_rd_en = 1'b1;
        tick();
        check("fwft9_udf", f_underflow, 1);
        f_clr_err = 1'b1;
        tick();
        check("fwft_clr_vs_event", f_underflow, 1);
        f_rd_en = 1'b0;
        tick();
        f_clr_err = 1'b0;
        check("fwft_clr", f_underflow, 0);

        // FWFT: steady stream with one word in RAM, head written the edge before.
        f_wr_en   = 1'b1;
        f_wr_data = 32'h300;
        tick();
        f_wr_en = 1'b0;
        tick();
        tick();
        check("fwft_str_first", f_rd_data, 32'h300);
        for (int c = 0; c < 4; c++) begin
            f_wr_en   = 1'b1;
            f_wr_data = 32'h301 + c;
            f_rd_en   = (c >= 1);
            tick();
            if (c >= 1) begin
                check("fwft_str_data", f_rd_data, 32'h300 + c);
                check("fwft_str_valid", f_rd_valid, 1);
                check("fwft_str_level", f_water_level, 2);
            end
        end
        f_wr_en = 1'b0;
        f_rd_en = 1'b1;
        tick();
        check("fwft_str_last", f_rd_data, 32'h304);
        check("fwft_str_last_level", f_water_level, 1);
        tick();
        f_rd_en = 1'b0;
        check("fwft_str_drained", f_rd_valid, 0);
        check("fwft_str_level0", f_water_level, 0);
        check("fwft_str_no_udf", f_underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
